// File: rtl/transconv_seq_pkg.sv
// rtl/transconv_seq_pkg.sv - shared states, constants and address helper for the transconv sequencer
package transconv_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR_PRE,
    S_LOAD,
    S_EMIT,
    S_CLR_POST,
    S_DONE
  } state_t;

  // Length of each datapath clear window (before and after a tile).
  localparam int CLR_CYCLES = 2;

  // Output pixel address for emit index e of input row r: r*4W + e.
  function automatic logic [31:0] out_addr(input logic [31:0] r,
                                           input logic [31:0] e,
                                           input logic [31:0] w);
    return (r * w * 32'd4) + e;
  endfunction

endpackage

// File: rtl/transconv_seq_wrpipe.sv
// rtl/transconv_seq_wrpipe.sv - fixed-latency delay line aligning write strobe/address with tc_pixel
module transconv_seq_wrpipe
  import transconv_seq_pkg::*;
#(
  parameter int AW  = 16,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          src_en,
  input  logic [AW-1:0] src_addr,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr
);

  generate
    if (LAT == 0) begin : g_bypass
      assign wr_en   = src_en;
      assign wr_addr = src_addr;
    end else begin : g_pipe
      logic [LAT-1:0] en_q;
      logic [AW-1:0]  addr_q [LAT];

      // Shift the emit strobe and its address LAT stages so writes land with the pixel.
      always_ff @(posedge clk) begin
        if (!rst) begin
          en_q <= '0;
          for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
        end else begin
          en_q[0]   <= src_en;
          addr_q[0] <= src_addr;
          for (int i = 1; i < LAT; i++) begin
            en_q[i]   <= en_q[i-1];
            addr_q[i] <= addr_q[i-1];
          end
        end
      end

      assign wr_en   = en_q[LAT-1];
      assign wr_addr = addr_q[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/transconv_seq.sv
// rtl/transconv_seq.sv - tile sequencer driving one transconv datapath and its line buffers
module transconv_seq
  import transconv_seq_pkg::*;
#(
  parameter int MAX_W   = 128,
  parameter int MAX_H   = 128,
  parameter int AW      = 16,
  parameter int PIX_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    cfg_width,
  input  logic [7:0]    cfg_height,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          tc_rst,
  output logic          tc_rw,
  output logic          tc_hop,
  output logic          tc_flip,
  output logic [7:0]    tc_width,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr
);

  // Counters cover the longest phase, one emit row pair of 4*MAX_W cycles.
  localparam int CW = $clog2(4 * MAX_W);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        state;
  logic [7:0]    h_lat;
  logic [CW-1:0] r;
  logic [CW-1:0] c;
  logic [CW-1:0] e;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] last_c;
  logic [CW-1:0] last_e;
  logic [CW-1:0] last_r;
  logic          src_en;
  logic [AW-1:0] src_addr;

  // Terminal counts for the current tile; 4W wraps to 0 at MAX_W so the -1 still lands on the last index.
  always_comb begin
    last_c = CW'(tc_width) - ONE;
    last_e = CW'({tc_width, 2'b00}) - ONE;
    last_r = CW'(h_lat) - ONE;
    cnt_nx = cnt + ONE;
  end

  // Each emit cycle produces one output pixel at r*4W+e.
  always_comb begin
    src_en   = (state == S_EMIT);
    src_addr = AW'(out_addr(32'(r), 32'(e), 32'(tc_width)));
  end

  // Tile FSM; all datapath/buffer controls are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      h_lat    <= '0;
      r        <= '0;
      c        <= '0;
      e        <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      tc_rst   <= 1'b0;
      tc_rw    <= 1'b1;
      tc_hop   <= 1'b1;
      tc_flip  <= 1'b0;
      tc_width <= '0;
    end else begin
      done   <= 1'b0;
      tc_hop <= 1'b1;
      case (state)
        S_IDLE: begin
          tc_rst <= 1'b1;
          tc_rw  <= 1'b1;
          rd_en  <= 1'b0;
          busy   <= 1'b0;
          cnt    <= '0;
          if (start) begin
            tc_width <= cfg_width;
            h_lat    <= cfg_height;
            busy     <= 1'b1;
            if (cfg_width == 8'd0 || cfg_height == 8'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_CLR_PRE;
              tc_rst  <= 1'b0;
              tc_flip <= 1'b0;
              r       <= '0;
            end
          end
        end

        S_CLR_PRE: begin
          if (cnt == CW'(CLR_CYCLES - 1)) begin
            state   <= S_LOAD;
            tc_rst  <= 1'b1;
            tc_rw   <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            c       <= '0;
          end else begin
            cnt <= cnt_nx;
          end
        end

        S_LOAD: begin
          if (c == last_c) begin
            state <= S_EMIT;
            rd_en <= 1'b0;
            tc_rw <= 1'b0;
            e     <= '0;
          end else begin
            c       <= c + ONE;
            rd_addr <= rd_addr + AW'(1);
          end
        end

        S_EMIT: begin
          if (e == last_e) begin
            tc_flip <= ~tc_flip;
            if (r == last_r) begin
              state  <= S_CLR_POST;
              cnt    <= '0;
              tc_rst <= (PIX_LAT > 0);
            end else begin
              state   <= S_LOAD;
              r       <= r + ONE;
              c       <= '0;
              tc_rw   <= 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= rd_addr + AW'(1);
            end
          end else begin
            e <= e + ONE;
          end
        end

        S_CLR_POST: begin
          // Hold the datapath alive until the last pixel is written, then clear it.
          if (cnt == CW'(PIX_LAT + CLR_CYCLES - 1)) begin
            state  <= S_DONE;
            tc_rst <= 1'b1;
            done   <= 1'b1;
          end else begin
            cnt    <= cnt_nx;
            tc_rst <= (cnt_nx < CW'(PIX_LAT));
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          tc_rst <= 1'b1;
          tc_rw  <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  transconv_seq_wrpipe #(
    .AW  (AW),
    .LAT (PIX_LAT)
  ) u_wrpipe (
    .clk      (clk),
    .rst      (rst),
    .src_en   (src_en),
    .src_addr (src_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr)
  );

endmodule

// File: tb/tb_transconv_seq.sv
// tb/tb_transconv_seq.sv - directed self-checking bench for transconv_seq
module tb_transconv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_width;
  logic [7:0]  cfg_height;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic        tc_rst;
  logic        tc_rw;
  logic        tc_hop;
  logic        tc_flip;
  logic [7:0]  tc_width;
  logic        wr_en;
  logic [15:0] wr_addr;

  int n_chk;
  int n_pass;

  transconv_seq #(
    .MAX_W   (128),
    .MAX_H   (128),
    .AW      (16),
    .PIX_LAT (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .tc_rst     (tc_rst),
    .tc_rw      (tc_rw),
    .tc_hop     (tc_hop),
    .tc_flip    (tc_flip),
    .tc_width   (tc_width),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reset-value vector: {busy,done,rd_en,wr_en,tc_rst,tc_rw,tc_hop,tc_flip}
  task automatic chk_reset_state(input string tag);
    chk({tag, " ctl"}, int'({busy, done, rd_en, wr_en, tc_rst, tc_rw, tc_hop, tc_flip}), 'b0000_0110);
    chk({tag, " rd_addr"}, int'(rd_addr), 0);
    chk({tag, " wr_addr"}, int'(wr_addr), 0);
    chk({tag, " tc_width"}, int'(tc_width), 0);
  endtask

  // Start one tile on the current negedge (cycle 0) and observe cycles 1.. until 8 past done.
  task automatic run_tile(input string nm, input int w, input int h, input bit poke,
                          input int exp_done, input int exp_first_wr,
                          input int exp_flips, input int exp_rstlo);
    int  rd_cnt, wr_cnt, rd_err, wr_err, rw_err;
    int  done_cnt, done_cyc, first_wr, rstlo, flips;
    bit  poked;
    rd_cnt = 0; wr_cnt = 0; rd_err = 0; wr_err = 0; rw_err = 0;
    done_cnt = 0; done_cyc = 0; first_wr = 0; rstlo = 0; flips = 0; poked = 0;
    cfg_width  = 8'(w);
    cfg_height = 8'(h);
    start      = 1'b1;
    for (int cyc = 1; cyc <= 2000 && (done_cyc == 0 || cyc <= done_cyc + 8); cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en) begin
        if (int'(rd_addr) != rd_cnt) rd_err++;
        if (!tc_rw) rw_err++;
        if (w > 0 && (rd_cnt % w) == 0 && tc_flip) flips |= (1 << (rd_cnt / w));
        rd_cnt++;
      end
      if (wr_en) begin
        if (int'(wr_addr) != wr_cnt) wr_err++;
        if (wr_cnt == 0) first_wr = cyc;
        wr_cnt++;
      end
      if (busy && !tc_rst) rstlo++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (poke && !poked && busy && !tc_rw && !rd_en) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end
    chk({nm, " done_seen"}, int'(done_cyc != 0), 1);
    chk({nm, " done_cycle"}, done_cyc, exp_done);
    chk({nm, " done_pulses"}, done_cnt, 1);
    chk({nm, " rd_count"}, rd_cnt, w * h);
    chk({nm, " rd_order"}, rd_err, 0);
    chk({nm, " rd_rw"}, rw_err, 0);
    chk({nm, " wr_count"}, wr_cnt, 4 * w * h);
    chk({nm, " wr_order"}, wr_err, 0);
    chk({nm, " first_wr"}, first_wr, exp_first_wr);
    chk({nm, " flips"}, flips, exp_flips);
    chk({nm, " clr_cycles"}, rstlo, exp_rstlo);
    chk({nm, " tc_width"}, int'(tc_width), w);
    chk({nm, " idle_after"}, int'({busy, tc_rst, tc_hop}), 'b011);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    start = 1'b0;
    cfg_width = 8'd0;
    cfg_height = 8'd0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("idle tc_rst", int'(tc_rst), 1);

    // 4x4: 2 + 80 + 1 + 2 + 1 = 86; first write one cycle after EMIT starts at cycle 7
    run_tile("t4x4", 4, 4, 1'b0, 86, 8, 'b1010, 4);
    // 1x1: 2 + 5 + 1 + 2 + 1 = 11
    run_tile("t1x1", 1, 1, 1'b0, 11, 5, 0, 4);
    // 3x2: 2 + 30 + 1 + 2 + 1 = 36
    run_tile("t3x2", 3, 2, 1'b0, 36, 7, 'b10, 4);
    // start pulsed during EMIT of row 0 must be ignored
    run_tile("poke", 4, 4, 1'b1, 86, 8, 'b1010, 4);

    // Abort mid-LOAD of row 2 (rd_addr 9 = r2,c1)
    cfg_width  = 8'd4;
    cfg_height = 8'd4;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !(rd_en && rd_addr == 16'd9); i++) @(negedge clk);
    chk("abort reached row2", int'(rd_en && rd_addr == 16'd9), 1);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("abort");
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort no done", int'({busy, done}), 0);
    run_tile("after_abort", 4, 4, 1'b0, 86, 8, 'b1010, 4);

    // Zero width: accepted, goes straight to DONE, no buffer traffic
    run_tile("w0", 0, 3, 1'b0, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
